memory_dump_reader: RTL and testbench
=====================================

Name: memory_dump_reader

Overview:
- Bus initiator that reads a contiguous byte region of global memory over the memory bus and streams it out one byte per cycle on a valid/ready port.
- It is the readback counterpart of the initial code/data segment loader. It lets a testbench or debug port compare memory contents (e.g. DATA_SEGMENT_START region after a run) against the assembler's .bin.data image.
- Sits beside the fetch stage as a second requester on the memory bus; the DRAM is the responder.

Parameters:
ADDR_W, 21, physical byte address width (matches phys_memory_address_t)
WORD_BYTES, 8, bytes per bus read beat; bus data width = 8*WORD_BYTES
LEN_W, 21, width of the byte-count field

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; latches start_addr/length when idle
start_addr  in  ADDR_W  first byte address, any alignment
length  in  LEN_W  number of bytes to dump
busy  out  1  high from accepted start until done pulse
done  out  1  one-cycle pulse after last byte accepted (or immediately for length 0)
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  DRAM accepts request
mem_req_addr  out  ADDR_W  word-aligned read address (low log2(WORD_BYTES) bits zero)
mem_rsp_valid  in  1  read data valid, one cycle, exactly one per accepted request
mem_rsp_data  in  8*WORD_BYTES  read data, byte k at bits [8k+7:8k] (PACK8 little-endian order)
out_valid  out  1  output byte valid
out_ready  in  1  consumer accepts byte
out_data  out  8  byte value
out_addr  out  ADDR_W  byte address of out_data

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, done, mem_req_valid, out_valid = 0; mem_req_addr, out_data, out_addr = 0. Reset mid-transfer abandons it; any response arriving after reset release while IDLE is ignored.
- States: IDLE, REQ, WAIT_RSP, DRAIN, FINISH.
- IDLE:
  - start=1 with length=0 -> FINISH; busy high for that one cycle only.
  - start=1 with length>0 -> latch cur_addr=start_addr and remaining=length, set busy, go to REQ.
  - start while not IDLE is ignored.
- REQ:
  - mem_req_valid=1 and mem_req_addr = cur_addr with low bits cleared.
  - Hold valid and addr stable until mem_req_ready.
  - On the handshake, go to WAIT_RSP.
- WAIT_RSP:
  - On mem_rsp_valid, capture the word into the 64-bit buffer and set byte index = cur_addr low bits.
  - Go to DRAIN.
  - No timeout; waits indefinitely.
- DRAIN:
  - out_valid=1, out_data = buffer byte[index], out_addr = cur_addr.
  - On out_valid&&out_ready: cur_addr+=1 (wraps modulo 2^ADDR_W) and remaining-=1.
  - If remaining becomes 0 -> FINISH. Else, if index was WORD_BYTES-1 -> REQ (next word). Else stay with index+1.
  - out_data/out_addr stable while out_valid && !out_ready.
- FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE. A start in the same cycle as done is ignored.
- Unaligned start: leading bytes of the first word are skipped. A partial final word: trailing bytes are never emitted.
- At most one outstanding request. A request is never issued while the buffer still holds undelivered bytes.
- Throughput: 1 byte/cycle within a word; minimum 2-cycle bubble per word (REQ handshake + response).

Decomposition:
- Shared package holds:
  - phys_memory_address_t and WORD_BYTES.
  - CODE_SEGMENT_START / DATA_SEGMENT_START.
  - the mem_req/mem_rsp field typedefs, shared with DRAM and fetch stage.
  - the dump_state_t enum.
- Natural sub-module: dump_byte_serializer (64-bit buffer, index counter, valid/ready output register). The top block holds the FSM and address/length counters.

Test Plan:
- Aligned dump: start_addr=DATA_SEGMENT_START, length=16, DRAM holds bytes 0x00..0x0F, out_ready=1 -> 2 requests (addr base, base+8); 16 bytes 0x00..0x0F in order with out_addr base..base+15; done one cycle after last byte.
- Unaligned/partial: start_addr=0x0003, length=7, memory[n]=n -> requests 0x0000 and 0x0008; bytes 0x03..0x09; no bytes from 0x0A..0x0F are emitted.
- Backpressure: length=8; toggle out_ready 1,0,0,1 repeating and stall mem_req_ready low for 5 cycles -> out_data/out_addr and mem_req_addr held stable while stalled; all 8 bytes delivered exactly once.
- Zero length and ignored start: start with length=0 -> done pulse next cycle with no mem_req_valid. A second start while busy (length=4) -> original 16-byte dump completes unchanged.
- Wrap-around: start_addr=0x1FFFFE, length=4 -> bytes from 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001; requests 0x1FFFF8 then 0x000000.
- Async reset mid-DRAIN: assert rst_n=0 between clock edges during byte 3 of 8 -> out_valid, mem_req_valid, and busy drop immediately. After release the block stays IDLE, and the next start performs a clean full dump.

Source files
------------

// File: rtl/memory_dump_reader_pkg.sv
// Shared memory-bus definitions for the fetch stage, DRAM model and dump reader.
package memory_dump_reader_pkg;

  localparam int PHYS_ADDR_W    = 21;
  localparam int BUS_WORD_BYTES = 8;

  typedef logic [PHYS_ADDR_W-1:0] phys_memory_address_t;

  localparam phys_memory_address_t CODE_SEGMENT_START = 21'h00_0000;
  localparam phys_memory_address_t DATA_SEGMENT_START = 21'h01_0000;

  typedef struct packed {
    logic                 valid;
    phys_memory_address_t addr;
  } mem_req_t;

  typedef struct packed {
    logic                          valid;
    logic [8*BUS_WORD_BYTES-1:0]   data;
  } mem_rsp_t;

  typedef enum logic [2:0] {
    DS_IDLE     = 3'd0,
    DS_REQ      = 3'd1,
    DS_WAIT_RSP = 3'd2,
    DS_DRAIN    = 3'd3,
    DS_FINISH   = 3'd4
  } dump_state_t;

endpackage

// File: rtl/memory_dump_reader_serializer.sv
// Holds one fetched bus word and presents its bytes one at a time on a
// registered valid/ready port, starting at the byte index given on load.
module dump_byte_serializer #(
  parameter int WORD_BYTES = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic [8*WORD_BYTES-1:0]         load_data,
  input  logic [$clog2(WORD_BYTES)-1:0]   load_idx,
  input  logic                            last_byte,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [7:0]                      out_data,
  output logic                            idx_last
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  logic [8*WORD_BYTES-1:0] buf_r;
  logic [IDX_W-1:0]        idx_r;
  logic                    valid_r;
  logic [7:0]              data_r;
  logic [IDX_W-1:0]        idx_inc_s;

  function automatic logic [7:0] pick_byte(input logic [8*WORD_BYTES-1:0] w,
                                           input logic [IDX_W-1:0] i);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (i == k[IDX_W-1:0]) b = w[8*k +: 8];
    end
    return b;
  endfunction

  assign idx_inc_s = idx_r + IDX_W'(1);
  assign idx_last  = (idx_r == IDX_W'(WORD_BYTES - 1));
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Word capture and per-byte advance; the word's final byte or the dump's last byte ends the drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r   <= {(8*WORD_BYTES){1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      valid_r <= 1'b0;
      data_r  <= 8'h00;
    end else if (load) begin
      buf_r   <= load_data;
      idx_r   <= load_idx;
      valid_r <= 1'b1;
      data_r  <= pick_byte(load_data, load_idx);
    end else if (valid_r && out_ready) begin
      if (last_byte || idx_last) begin
        valid_r <= 1'b0;
      end else begin
        idx_r  <= idx_inc_s;
        data_r <= pick_byte(buf_r, idx_inc_s);
      end
    end
  end

endmodule

// File: rtl/memory_dump_reader.sv
// Bus initiator that reads a contiguous byte range of memory one word at a
// time and streams it out a byte per cycle with its address.
module memory_dump_reader
  import memory_dump_reader_pkg::*;
#(
  parameter int ADDR_W     = PHYS_ADDR_W,
  parameter int WORD_BYTES = BUS_WORD_BYTES,
  parameter int LEN_W      = 21
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         start_addr,
  input  logic [LEN_W-1:0]          length,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_W-1:0]         mem_req_addr,
  input  logic                      mem_rsp_valid,
  input  logic [8*WORD_BYTES-1:0]   mem_rsp_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_data,
  output logic [ADDR_W-1:0]         out_addr
);

  localparam int IDX_W = $clog2(WORD_BYTES);

  dump_state_t       state_r, state_nxt_s;
  logic [ADDR_W-1:0] cur_addr_r, cur_addr_nxt_s, req_addr_r, req_addr_nxt_s;
  logic [LEN_W-1:0]  remain_r, remain_nxt_s;
  logic              busy_r, busy_nxt_s, done_r, done_nxt_s;
  logic              req_valid_r, req_valid_nxt_s;
  logic              out_fire_s, load_s, last_byte_s, idx_last_s;

  assign out_fire_s    = out_valid && out_ready;
  assign load_s        = (state_r == DS_WAIT_RSP) && mem_rsp_valid;
  assign last_byte_s   = (remain_r == LEN_W'(1));
  assign busy          = busy_r;
  assign done          = done_r;
  assign mem_req_valid = req_valid_r;
  assign mem_req_addr  = req_addr_r;
  assign out_addr      = cur_addr_r;

  // State, counters and the outputs registered from next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= DS_IDLE;
      cur_addr_r  <= {ADDR_W{1'b0}};
      remain_r    <= {LEN_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      req_valid_r <= 1'b0;
      req_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      cur_addr_r  <= cur_addr_nxt_s;
      remain_r    <= remain_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      req_valid_r <= req_valid_nxt_s;
      req_addr_r  <= req_addr_nxt_s;
    end
  end

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      DS_IDLE: begin
        if (start) state_nxt_s = (length == {LEN_W{1'b0}}) ? DS_FINISH : DS_REQ;
        else       state_nxt_s = DS_IDLE;
      end
      DS_REQ: begin
        if (mem_req_ready) state_nxt_s = DS_WAIT_RSP;
        else               state_nxt_s = DS_REQ;
      end
      DS_WAIT_RSP: begin
        if (mem_rsp_valid) state_nxt_s = DS_DRAIN;
        else               state_nxt_s = DS_WAIT_RSP;
      end
      DS_DRAIN: begin
        if (!out_fire_s)     state_nxt_s = DS_DRAIN;
        else if (last_byte_s) state_nxt_s = DS_FINISH;
        else if (idx_last_s)  state_nxt_s = DS_REQ;
        else                  state_nxt_s = DS_DRAIN;
      end
      DS_FINISH: state_nxt_s = DS_IDLE;
      default:   state_nxt_s = DS_IDLE;
    endcase
  end

  // Counter updates and next values of the registered outputs
  always_comb begin
    cur_addr_nxt_s = cur_addr_r;
    remain_nxt_s   = remain_r;
    if ((state_r == DS_IDLE) && start && (length != {LEN_W{1'b0}})) begin
      cur_addr_nxt_s = start_addr;
      remain_nxt_s   = length;
    end else if ((state_r == DS_DRAIN) && out_fire_s) begin
      cur_addr_nxt_s = cur_addr_r + ADDR_W'(1);
      remain_nxt_s   = remain_r - LEN_W'(1);
    end else begin
      cur_addr_nxt_s = cur_addr_r;
      remain_nxt_s   = remain_r;
    end
    busy_nxt_s      = (state_nxt_s != DS_IDLE);
    done_nxt_s      = (state_nxt_s == DS_FINISH);
    req_valid_nxt_s = (state_nxt_s == DS_REQ);
    if (state_nxt_s == DS_REQ) begin
      req_addr_nxt_s = {cur_addr_nxt_s[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
    end else begin
      req_addr_nxt_s = req_addr_r;
    end
  end

  dump_byte_serializer #(
    .WORD_BYTES (WORD_BYTES)
  ) u_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_s),
    .load_data  (mem_rsp_data),
    .load_idx   (cur_addr_r[IDX_W-1:0]),
    .last_byte  (last_byte_s),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .idx_last   (idx_last_s)
  );

endmodule

// File: tb/tb_memory_dump_reader.sv
// Scoreboard bench: a DRAM responder and an output consumer check the dump
// reader against a byte-level model of the memory image.
module tb_memory_dump_reader;
  import memory_dump_reader_pkg::*;

  localparam int AW = 21;
  localparam int LW = 21;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done, mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [AW-1:0] mem_req_addr, out_addr;
  logic [63:0]   mem_rsp_data;
  logic          out_valid, out_ready;
  logic [7:0]    out_data;

  memory_dump_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_fire_cyc = 0;
  int out_mode = 0;
  int req_stall = 0;
  bit stray_rsp = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [AW-1:0]   exp_req_q[$];
  logic [AW+7:0]   exp_byte_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0] ^ seed;
  endfunction

  function automatic logic [63:0] mem_word(input logic [AW-1:0] wa);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = mem_byte(wa + AW'(k));
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // DRAM responder: random stalls and latency, checks every accepted request address
  initial begin
    int pend = 0;
    int cnt = 0;
    int stall_left = 0;
    bit in_req = 1'b0;
    logic [AW-1:0] held_addr = '0;
    logic [AW-1:0] pend_addr = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 64'h0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (!rst_n) begin
        pend = 0;
        in_req = 1'b0;
        mem_req_ready = 1'b0;
      end else begin
        if (stray_rsp) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = {$urandom, $urandom};
          stray_rsp = 1'b0;
        end else if (pend != 0) begin
          if (cnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(pend_addr);
            pend = 0;
          end else cnt--;
        end
        if (mem_req_valid) begin
          if (!in_req) begin
            in_req = 1'b1;
            held_addr = mem_req_addr;
            stall_left = (req_stall < 0) ? int'($urandom_range(0, 2)) : req_stall;
          end else check("req_addr_stable", 32'(mem_req_addr), 32'(held_addr));
          if (stall_left > 0) begin
            mem_req_ready = 1'b0;
            stall_left--;
          end else begin
            mem_req_ready = 1'b1;
            in_req = 1'b0;
            if (exp_req_q.size() == 0) check("req_unexpected", 32'(mem_req_valid), 32'd0);
            else check("req_addr", 32'(mem_req_addr), 32'(exp_req_q.pop_front()));
            pend = 1;
            pend_addr = mem_req_addr;
            cnt = $urandom_range(0, 3);
          end
        end else begin
          mem_req_ready = 1'b0;
          in_req = 1'b0;
        end
      end
    end
  end

  // Output consumer: drives out_ready, checks each accepted byte and hold stability
  initial begin
    bit holding = 1'b0;
    int phase = 0;
    logic [7:0] hd = '0;
    logic [AW-1:0] ha = '0;
    logic [AW+7:0] e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (out_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = ((phase % 4) == 0) || ((phase % 4) == 3); phase++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid) begin
        if (holding) begin
          check("out_data_stable", 32'(out_data), 32'(hd));
          check("out_addr_stable", 32'(out_addr), 32'(ha));
        end
        if (out_ready) begin
          holding = 1'b0;
          if (exp_byte_q.size() == 0) check("byte_unexpected", 32'(out_valid), 32'd0);
          else begin
            e = exp_byte_q.pop_front();
            check("out_data", 32'(out_data), 32'(e[7:0]));
            check("out_addr", 32'(out_addr), 32'(e[AW+7:8]));
          end
          last_fire_cyc = cyc + 1;
        end else begin
          holding = 1'b1;
          hd = out_data;
          ha = out_addr;
        end
      end else holding = 1'b0;
    end
  end

  task automatic expect_dump(input logic [AW-1:0] a, input int n);
    logic [AW-1:0] ba, wa, last_wa;
    last_wa = '0;
    for (int i = 0; i < n; i++) begin
      ba = a + AW'(i);
      wa = {ba[AW-1:3], 3'b000};
      if (i == 0 || wa != last_wa) exp_req_q.push_back(wa);
      last_wa = wa;
      exp_byte_q.push_back({ba, mem_byte(ba)});
    end
  endtask

  task automatic run_dump(input logic [AW-1:0] a, input int n, input bit poke_busy, input bit poke_done);
    int t;
    expect_dump(a, n);
    @(negedge clk);
    start = 1'b1; start_addr = a; length = LW'(n);
    @(negedge clk);
    start = 1'b0; start_addr = AW'($urandom); length = LW'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    t = 0;
    while (!done && t < 5000) begin
      if (poke_busy && t == 3) begin
        start = 1'b1; length = LW'(4); start_addr = AW'($urandom);
      end else start = 1'b0;
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    if (n == 0) check("zero_len_done_latency", 32'(t), 32'd0);
    else check("done_after_last_byte", 32'(cyc), 32'(last_fire_cyc));
    check("bytes_outstanding", 32'(exp_byte_q.size()), 32'd0);
    check("reqs_outstanding", 32'(exp_req_q.size()), 32'd0);
    if (poke_done) begin
      start = 1'b1; length = LW'(3); start_addr = AW'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_cleared", 32'(busy), 32'd0);
  endtask

  task automatic reset_mid_drain(input logic [AW-1:0] a);
    int t;
    expect_dump(a, 8);
    @(negedge clk);
    start = 1'b1; start_addr = a; length = LW'(8);
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!(out_valid && out_addr == a + AW'(2)) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reached_byte3", 32'(out_addr), 32'(a + AW'(2)));
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    exp_byte_q.delete();
    exp_req_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray_rsp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_after_rst_busy", 32'(busy), 32'd0);
      check("idle_after_rst_out", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #3;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_req_valid", 32'(mem_req_valid), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_req_addr", 32'(mem_req_addr), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_addr", 32'(out_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_dump(DATA_SEGMENT_START, 16, 1'b0, 1'b0);
    run_dump(21'h00_0003, 7, 1'b0, 1'b0);
    out_mode = 1; req_stall = 5;
    run_dump(DATA_SEGMENT_START + 21'h40, 8, 1'b0, 1'b0);
    out_mode = 0; req_stall = 0;
    run_dump(DATA_SEGMENT_START, 0, 1'b0, 1'b0);
    run_dump(DATA_SEGMENT_START, 16, 1'b1, 1'b0);
    run_dump(21'h1F_FFFE, 4, 1'b0, 1'b0);
    run_dump(CODE_SEGMENT_START + 21'h100, 5, 1'b0, 1'b1);
    reset_mid_drain(DATA_SEGMENT_START + 21'h80);
    run_dump(DATA_SEGMENT_START + 21'h80, 8, 1'b0, 1'b0);

    out_mode = 2; req_stall = -1;
    for (int r = 0; r < 25; r++) begin
      logic [AW-1:0] ra;
      seed = 8'($urandom);
      ra = (r % 4 == 0) ? AW'(21'h1F_FFF0 + AW'($urandom_range(0, 15))) : AW'($urandom);
      run_dump(ra, $urandom_range(0, 40), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
